// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the LSU memory port: data/address widths of the
// bram32 side, RV32I load/store funct3 codes and a legality helper.
package lsu_mem_port_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int RAM_ADDR_WIDTH = 12;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Stores only have the three signed-less sizes; loads add the unsigned pair.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Size alignment keys off funct3[1:0] (01 = half, 10 = word) for both
  // loads and stores, so one check covers every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between the core and a 32-bit BRAM word.
//   funct3, off  : size/sign code and byte offset of the access
//   wdata        : right-aligned store data
//   rword        : raw word from memory
//   byte_enb     : write lane mask
//   w_dat        : store data replicated across lanes
//   rdata        : extracted and sign/zero-extended load data
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [3:0]            byte_enb,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] shifted;

  // Replicating the data means the BRAM needs no shifter; the mask picks lanes.
  always_comb begin
    byte_enb = 4'b1111;
    w_dat    = wdata;
    case (funct3[1:0])
      2'b00: begin
        byte_enb = 4'b0001 << off;
        w_dat    = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_enb = 4'b0011 << off;
        w_dat    = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rword >> {off, 3'b000};
    case (funct3)
      F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  rdata = {24'h0, shifted[7:0]};
      F3_LHU:  rdata = {16'h0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator in front of bram32: one core op becomes one BRAM
// access, with alignment/funct3/range checking and a configurable read
// latency for registered BRAMs. One op in flight at a time.
//   clk, rst_n                 : clock, async active-low reset
//   req_*                      : core request (valid/ready), latched on accept
//   rsp_*                      : core response (valid/ready), held until taken
//   mem_w_* / mem_byte_enb     : bram32 write port
//   mem_r_* / mem_r_dat        : bram32 read port
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_WIDTH,
  parameter int MEM_RD_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_dat,
  output logic                  mem_w_enb,
  output logic [3:0]            mem_byte_enb,
  output logic [ADDR_W-1:0]     mem_r_addr,
  output logic                  mem_r_enb,
  input  logic [DATA_WIDTH-1:0] mem_r_dat
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]            funct3;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] wdata;
  } op_t;

  state_t                state;
  op_t                   op;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  req_err;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdat;
  logic [DATA_WIDTH-1:0] ext;

  always_comb begin
    req_err = !f3_legal(req_we, req_funct3) ||
              misaligned(req_funct3, req_addr[1:0]) ||
              ((req_addr >> ADDR_W) != 32'h0);
  end

  lsu_lane_align u_align (
    .funct3   (op.funct3),
    .off      (op.addr[1:0]),
    .wdata    (op.wdata),
    .rword    (mem_r_dat),
    .byte_enb (be),
    .w_dat    (wdat),
    .rdata    (ext)
  );

  // cnt counts remaining RD cycles after the current one; the word is
  // captured when it reaches zero, i.e. on the (MEM_RD_LAT+1)th RD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op      <= '0;
      cnt     <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op      <= '{funct3: req_funct3, addr: req_addr[ADDR_W-1:0], wdata: req_wdata};
          cnt     <= 2'(MEM_RD_LAT);
          rdata_q <= '0;
          err_q   <= req_err;
          state   <= req_err ? S_RESP : (req_we ? S_WR : S_RD);
        end
        S_WR: state <= S_RESP;
        S_RD: begin
          if (cnt == 2'd0) begin
            rdata_q <= ext;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Everything below is decoded from state so async reset clears it at once.
  always_comb begin
    req_ready    = (state == S_IDLE);
    rsp_valid    = (state == S_RESP);
    rsp_rdata    = rsp_valid ? rdata_q : '0;
    rsp_err      = rsp_valid & err_q;
    mem_w_enb    = (state == S_WR);
    mem_w_addr   = mem_w_enb ? op.addr : '0;
    mem_w_dat    = mem_w_enb ? wdat : '0;
    mem_byte_enb = mem_w_enb ? be : 4'b0000;
    mem_r_enb    = (state == S_RD);
    mem_r_addr   = mem_r_enb ? op.addr : '0;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] mem_w_addr, mem_r_addr;
  logic [31:0] mem_w_dat, mem_r_dat;
  logic        mem_w_enb, mem_r_enb;
  logic [3:0]  mem_byte_enb;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(12), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
    .mem_byte_enb(mem_byte_enb), .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb),
    .mem_r_dat(mem_r_dat)
  );

  // bram32 model with a LAT=2 registered read path
  logic [31:0] mem [1024];
  logic [31:0] p0 = 32'h0, p1 = 32'h0;
  assign mem_r_dat = p1;
  always @(posedge clk) begin
    if (mem_w_enb)
      for (int b = 0; b < 4; b++)
        if (mem_byte_enb[b]) mem[mem_w_addr[11:2]][8*b +: 8] <= mem_w_dat[8*b +: 8];
    p0 <= mem[mem_r_addr[11:2]];
    p1 <= p0;
  end

  always @(negedge clk) begin
    ncmp++;
    if (mem_r_enb && mem_w_enb) begin
      nfail++;
      $display("FAIL strobe_overlap: r_enb=%b w_enb=%b, required never both", mem_r_enb, mem_w_enb);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdat;
  } vec_t;

  task automatic do_op(input vec_t v, input string tag);
    int cyc = 0, wc = 0, rc = 0, lat;
    logic [3:0]  be_s = '0;
    logic [31:0] wd_s = '0, wa_s = '0;
    logic        leak = 1'b0;
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_w_enb) begin
        wc++; be_s = mem_byte_enb; wd_s = mem_w_dat; wa_s = 32'(mem_w_addr);
      end else if (mem_w_addr != 0 || mem_w_dat != 0 || mem_byte_enb != 0) leak = 1'b1;
      if (mem_r_enb) rc++;
      else if (mem_r_addr != 0) leak = 1'b1;
    end while (!rsp_valid && cyc < 20);
    lat = v.err ? 1 : (v.we ? 2 : LAT + 2);
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".err"}, 32'(rsp_err), 32'(v.err));
    check({tag, ".rdata"}, rsp_rdata, v.rdata);
    check({tag, ".w_cycles"}, 32'(wc), (v.we && !v.err) ? 32'd1 : 32'd0);
    check({tag, ".r_cycles"}, 32'(rc), (!v.we && !v.err) ? 32'(LAT + 1) : 32'd0);
    check({tag, ".idle_zero"}, 32'(leak), 32'd0);
    if (v.we && !v.err) begin
      check({tag, ".byte_enb"}, 32'(be_s), 32'(v.be));
      check({tag, ".w_dat"}, wd_s, v.wdat);
      check({tag, ".w_addr"}, wa_s, v.addr);
    end
  endtask

  vec_t vecs[$];
  logic quiet;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h80FF7F01;
    mem[8] = 32'h55AA1234;

    //            we    f3      addr      wdata         err   rdata         be       wdat
    vecs.push_back('{1'b0, F3_LB,  32'h012, 32'h0,        1'b0, 32'hFFFFFFFF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LBU, 32'h012, 32'h0,        1'b0, 32'h000000FF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LH,  32'h012, 32'h0,        1'b0, 32'hFFFF80FF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LHU, 32'h012, 32'h0,        1'b0, 32'h000080FF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LW,  32'h010, 32'h0,        1'b0, 32'h80FF7F01, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LH,  32'h010, 32'h0,        1'b0, 32'h00007F01, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LB,  32'h011, 32'h0,        1'b0, 32'h0000007F, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LW,  32'h006, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, F3_SH,  32'h011, 32'h1234,     1'b1, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LW,  32'h1000,32'h0,        1'b1, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b100, 32'h010, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, F3_SW,  32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF});
    vecs.push_back('{1'b1, F3_SB,  32'h013, 32'h000000A5, 1'b0, 32'h0,        4'h8, 32'hA5A5A5A5});
    vecs.push_back('{1'b1, F3_SH,  32'h012, 32'h00001234, 1'b0, 32'h0,        4'hC, 32'h12341234});
    vecs.push_back('{1'b0, F3_LW,  32'h010, 32'h0,        1'b0, 32'h1234BEEF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, F3_LBU, 32'h013, 32'h0,        1'b0, 32'h00000012, 4'h0, 32'h0});

    // reset state
    #3;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.strobes", {30'h0, mem_r_enb, mem_w_enb}, 32'd0);
    check("rst.byte_enb", 32'(mem_byte_enb), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // held response: LW 0x020 with rsp_ready low three cycles
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("hold.r_enb.c%0d", c), 32'(mem_r_enb), (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("hold.rsp_valid.c%0d", c), 32'(rsp_valid), (c == 4) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b1;
    for (int c = 5; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("hold.rsp_valid.c%0d", c), 32'(rsp_valid), 32'd1);
      check($sformatf("hold.req_ready.c%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("hold.rdata.c%0d", c), rsp_rdata, 32'h55AA1234);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold.released", 32'(rsp_valid), 32'd0);
    check("hold.no_same_cycle_accept", 32'(mem_r_enb), 32'd0);
    check("hold.req_ready_back", 32'(req_ready), 32'd1);
    req_valid = 1'b0;

    // reset in the middle of a read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst.r_enb_before", 32'(mem_r_enb), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.r_enb", 32'(mem_r_enb), 32'd0);
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || mem_r_enb) quiet = 1'b0;
    end
    check("midrst.no_rsp", 32'(quiet), 32'd1);
    do_op('{1'b0, F3_LW, 32'h010, 32'h0, 1'b0, 32'h1234BEEF, 4'h0, 32'h0}, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units, required finish earlier");
    $fatal(1);
  end

endmodule
